cl_tx_framer: RTL and testbench

- Transmit-side Camera Link base-configuration framer. It is the counterpart of the CLRX receive path.
- Input is a pixel stream on a valid/ready interface, with SOF carried on tuser and end-of-line on tlast. Each pixel is three 8-bit taps (ports A/B/C).
- Output is the 28-bit Channel Link parallel word that feeds the downstream 7:1 serializer. The word carries FVAL/LVAL/DVAL framing, with line and frame blanking inserted.
- Sits in the pixel-clock domain, between the test-pattern/video source and the OSERDES serializer.

---
 rtl/cl_tx_pkg.sv | 30 +++
 rtl/cl_tx_framer_if.sv | 11 +
 rtl/cl_tx_framer.sv | 177 +++++++++++++++++
 tb/tb_cl_tx_framer.sv | 255 +++++++++++++++++++++++++
 4 files changed

// File: rtl/cl_tx_pkg.sv
// Shared Camera Link definitions: FSM states, Channel Link word layout and tap offsets.
// Used by both the transmit framer and the receive-side checker.
package cl_tx_pkg;

    typedef enum logic [2:0] {
        IDLE    = 3'd0,
        FV_LEAD = 3'd1,
        LINE    = 3'd2,
        H_GAP   = 3'd3,
        FV_TAIL = 3'd4,
        V_GAP   = 3'd5
    } state_e;

    localparam int CL_WORD_W = 28;
    localparam int PIX_W     = 24;

    localparam int LVAL_BIT  = 24;
    localparam int FVAL_BIT  = 25;
    localparam int DVAL_BIT  = 26;
    localparam int SPARE_BIT = 27;

    localparam int TAP_A = 0;
    localparam int TAP_B = 8;
    localparam int TAP_C = 16;

    function automatic int max_int(input int a, input int b);
        return (a > b) ? a : b;
    endfunction

endpackage

// File: rtl/cl_tx_framer_if.sv
// Pixel stream into the framer: valid/ready with SOF on tuser and end-of-line on tlast.
interface cl_tx_framer_if;
    logic [23:0] s_tdata;
    logic        s_tvalid;
    logic        s_tready;
    logic        s_tuser;
    logic        s_tlast;

    modport master (output s_tdata, s_tvalid, s_tuser, s_tlast, input s_tready);
    modport slave  (input s_tdata, s_tvalid, s_tuser, s_tlast, output s_tready);
endinterface

// File: rtl/cl_tx_framer.sv
// Camera Link base-config transmit framer: pixel stream in, 28-bit Channel Link word out
// with FVAL/LVAL/DVAL framing and programmable line/frame blanking.
module cl_tx_framer
    import cl_tx_pkg::*;
#(
    parameter int H_BLANK   = 16,
    parameter int V_BLANK   = 64,
    parameter int FV_LV_DLY = 4,
    parameter int LV_FV_DLY = 4,
    parameter int CNT_W     = 16
) (
    input  logic                 px_clk,
    input  logic                 rst,
    input  logic                 enable,
    input  logic [CNT_W-1:0]     cfg_width,
    input  logic [CNT_W-1:0]     cfg_height,
    cl_tx_framer_if.slave        s,
    output logic [CL_WORD_W-1:0] DATA_OUT,
    output logic                 fval,
    output logic                 lval,
    output logic                 dval,
    output logic                 busy,
    output logic [CNT_W-1:0]     frame_cnt,
    output logic                 err_line,
    output logic                 err_sof
);

    // Single shared delay counter holds (cycles-1) for whichever blanking state is active.
    localparam int DLY_MAX = max_int(max_int(H_BLANK, V_BLANK), max_int(FV_LV_DLY, LV_FV_DLY));
    localparam int DLY_W   = (DLY_MAX < 2) ? 1 : $clog2(DLY_MAX);

    localparam logic [DLY_W-1:0] LD_LEAD = DLY_W'(FV_LV_DLY - 1);
    localparam logic [DLY_W-1:0] LD_HGAP = DLY_W'(H_BLANK - 1);
    localparam logic [DLY_W-1:0] LD_TAIL = DLY_W'(LV_FV_DLY - 1);
    localparam logic [DLY_W-1:0] LD_VGAP = DLY_W'(V_BLANK - 1);

    state_e                 state_q, state_d;
    logic [DLY_W-1:0]       dly_q, dly_d;
    logic [CNT_W-1:0]       px_q, px_d;
    logic [CNT_W-1:0]       ln_q, ln_d;
    logic [CNT_W-1:0]       width_q, width_d;
    logic [CNT_W-1:0]       height_q, height_d;
    logic [CNT_W-1:0]       fcnt_q, fcnt_d;
    logic [CL_WORD_W-1:0]   word_q, word_d;
    logic                   busy_q;
    logic                   err_line_q, err_line_d;
    logic                   err_sof_q, err_sof_d;
    logic                   tready;
    logic                   last_px;
    logic                   first_px;
    logic                   dly_done;

    assign last_px  = (px_q == width_q - CNT_W'(1));
    assign first_px = (px_q == '0) && (ln_q == '0);
    assign dly_done = (dly_q == '0);

    always_comb begin
        state_d    = state_q;
        dly_d      = dly_q;
        px_d       = px_q;
        ln_d       = ln_q;
        width_d    = width_q;
        height_d   = height_q;
        fcnt_d     = fcnt_q;
        word_d     = '0;
        err_line_d = 1'b0;
        err_sof_d  = 1'b0;
        tready     = 1'b0;

        unique case (state_q)
            IDLE: begin
                // Non-SOF beats are swallowed so the stream realigns on the next SOF.
                tready = s.s_tvalid & ~s.s_tuser;
                if (enable && s.s_tvalid && s.s_tuser) begin
                    width_d  = (cfg_width  == '0) ? CNT_W'(1) : cfg_width;
                    height_d = (cfg_height == '0) ? CNT_W'(1) : cfg_height;
                    px_d     = '0;
                    ln_d     = '0;
                    dly_d    = LD_LEAD;
                    state_d  = FV_LEAD;
                end
            end
            FV_LEAD: begin
                word_d[FVAL_BIT] = 1'b1;
                if (dly_done) state_d = LINE;
                else          dly_d   = dly_q - DLY_W'(1);
            end
            LINE: begin
                tready           = 1'b1;
                word_d[FVAL_BIT] = 1'b1;
                word_d[LVAL_BIT] = 1'b1;
                if (s.s_tvalid) begin
                    word_d[DVAL_BIT]     = 1'b1;
                    word_d[TAP_A +: 8]   = s.s_tdata[7:0];
                    word_d[TAP_B +: 8]   = s.s_tdata[15:8];
                    word_d[TAP_C +: 8]   = s.s_tdata[23:16];
                    err_line_d           = s.s_tlast ^ last_px;
                    err_sof_d            = s.s_tuser & ~first_px;
                    if (last_px) begin
                        px_d = '0;
                        if (ln_q == height_q - CNT_W'(1)) begin
                            dly_d   = LD_TAIL;
                            state_d = FV_TAIL;
                        end else begin
                            ln_d    = ln_q + CNT_W'(1);
                            dly_d   = LD_HGAP;
                            state_d = H_GAP;
                        end
                    end else begin
                        px_d = px_q + CNT_W'(1);
                    end
                end
            end
            H_GAP: begin
                word_d[FVAL_BIT] = 1'b1;
                if (dly_done) state_d = LINE;
                else          dly_d   = dly_q - DLY_W'(1);
            end
            FV_TAIL: begin
                word_d[FVAL_BIT] = 1'b1;
                if (dly_done) begin
                    fcnt_d  = fcnt_q + CNT_W'(1);
                    dly_d   = LD_VGAP;
                    state_d = V_GAP;
                end else begin
                    dly_d = dly_q - DLY_W'(1);
                end
            end
            V_GAP: begin
                if (dly_done) state_d = IDLE;
                else          dly_d   = dly_q - DLY_W'(1);
            end
            default: state_d = IDLE;
        endcase
        word_d[SPARE_BIT] = 1'b0;
    end

    always_ff @(posedge px_clk or posedge rst) begin
        if (rst) begin
            state_q    <= IDLE;
            dly_q      <= '0;
            px_q       <= '0;
            ln_q       <= '0;
            width_q    <= CNT_W'(1);
            height_q   <= CNT_W'(1);
            fcnt_q     <= '0;
            word_q     <= '0;
            busy_q     <= 1'b0;
            err_line_q <= 1'b0;
            err_sof_q  <= 1'b0;
        end else begin
            state_q    <= state_d;
            dly_q      <= dly_d;
            px_q       <= px_d;
            ln_q       <= ln_d;
            width_q    <= width_d;
            height_q   <= height_d;
            fcnt_q     <= fcnt_d;
            word_q     <= word_d;
            busy_q     <= (state_d != IDLE);
            err_line_q <= err_line_d;
            err_sof_q  <= err_sof_d;
        end
    end

    // Ready is held low while reset is asserted so no beat is acked mid-reset.
    assign s.s_tready = tready & ~rst;
    assign DATA_OUT   = word_q;
    assign fval       = word_q[FVAL_BIT];
    assign lval       = word_q[LVAL_BIT];
    assign dval       = word_q[DVAL_BIT];
    assign busy       = busy_q;
    assign frame_cnt  = fcnt_q;
    assign err_line   = err_line_q;
    assign err_sof    = err_sof_q;

endmodule

// File: tb/tb_cl_tx_framer.sv
// Directed bench for cl_tx_framer: 4x2 frames with short blanking, checked from a per-cycle output log.
module tb_cl_tx_framer;
    import cl_tx_pkg::*;

    logic        px_clk = 1'b0;
    logic        rst    = 1'b1;
    logic        enable = 1'b0;
    logic [15:0] cfg_width  = 16'd4;
    logic [15:0] cfg_height = 16'd2;
    logic [27:0] DATA_OUT;
    logic        fval, lval, dval, busy, err_line, err_sof;
    logic [15:0] frame_cnt;

    cl_tx_framer_if sif();

    cl_tx_framer #(
        .H_BLANK(2), .V_BLANK(3), .FV_LV_DLY(1), .LV_FV_DLY(1), .CNT_W(16)
    ) dut (
        .px_clk(px_clk), .rst(rst), .enable(enable),
        .cfg_width(cfg_width), .cfg_height(cfg_height), .s(sif),
        .DATA_OUT(DATA_OUT), .fval(fval), .lval(lval), .dval(dval), .busy(busy),
        .frame_cnt(frame_cnt), .err_line(err_line), .err_sof(err_sof)
    );

    always #5 px_clk = ~px_clk;

    int n_chk  = 0;
    int n_pass = 0;

    // {err_sof, err_line, dval, lval, fval, DATA_OUT} sampled every falling edge
    logic [32:0] lg[$];
    int          lg_start = 0;
    always @(negedge px_clk) lg.push_back({err_sof, err_line, dval, lval, fval, DATA_OUT});

    int          a_fv, a_fvrise, a_lead, a_tail, a_nlv, a_gap, a_stall, a_viol;
    int          a_el, a_es;
    int          a_lv[8];
    logic [23:0] a_el_dat, a_es_dat;
    logic [23:0] a_data[$];

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_chk++;
        assert (obs === exp) n_pass++;
        else $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    endtask

    task automatic analyze();
        logic [32:0] r;
        logic        fv, lv, dv, pfv, plv;
        int          tail;
        pfv = 1'b0; plv = 1'b0; tail = 0;
        a_fv = 0; a_fvrise = 0; a_lead = 0; a_tail = 0; a_nlv = 0; a_gap = 0;
        a_stall = 0; a_viol = 0; a_el = 0; a_es = 0; a_el_dat = '0; a_es_dat = '0;
        for (int i = 0; i < 8; i++) a_lv[i] = 0;
        a_data.delete();
        for (int k = lg_start; k < lg.size(); k++) begin
            r  = lg[k];
            fv = r[FVAL_BIT]; lv = r[LVAL_BIT]; dv = r[DVAL_BIT];
            if (r[28] !== fv || r[29] !== lv || r[30] !== dv || r[SPARE_BIT] !== 1'b0 ||
                (dv && !lv) || (lv && !fv) || (!dv && r[23:0] != 24'd0)) a_viol++;
            if (fv) a_fv++;
            if (fv && !pfv) a_fvrise++;
            if (lv && !plv) begin
                if (a_nlv == 1) a_gap = tail;
                a_nlv++;
                tail = 0;
            end
            if (lv && a_nlv >= 1 && a_nlv <= 8) a_lv[a_nlv-1]++;
            if (fv && !lv) begin
                if (a_nlv == 0) a_lead++;
                else            tail++;
            end
            if (lv && !dv) a_stall++;
            if (dv) a_data.push_back(r[23:0]);
            if (r[31]) begin a_el++; a_el_dat = r[23:0]; end
            if (r[32]) begin a_es++; a_es_dat = r[23:0]; end
            pfv = fv; plv = lv;
        end
        a_tail = tail;
    endtask

    task automatic send_beat(input logic [23:0] d, input logic u, input logic l, output int cyc);
        logic hs;
        sif.s_tdata = d; sif.s_tuser = u; sif.s_tlast = l; sif.s_tvalid = 1'b1;
        cyc = 0; hs = 1'b0;
        while (!hs && cyc < 200) begin
            @(negedge px_clk);
            hs = sif.s_tready;
            @(posedge px_clk); #1;
            cyc++;
        end
        if (!hs) chk("hs_timeout", {31'd0, hs}, 32'd1);
    endtask

    task automatic idle_bus();
        sif.s_tvalid = 1'b0; sif.s_tuser = 1'b0; sif.s_tlast = 1'b0; sif.s_tdata = '0;
    endtask

    // 4x2 frame of pixels 1..8; indices <0 disable the optional feature.
    task automatic send_frame(input int last_i, input int sof_i, input int stall_i,
                              input int stall_n, input int en_off_i);
        int cyc;
        for (int i = 0; i < 8; i++) begin
            send_beat(24'(i + 1), (i == 0) || (i == sof_i), (i % 4 == 3) || (i == last_i), cyc);
            if (i == en_off_i) enable = 1'b0;
            if (i == stall_i) begin
                sif.s_tvalid = 1'b0;
                repeat (stall_n) @(posedge px_clk);
                #1;
            end
        end
        idle_bus();
    endtask

    task automatic wait_idle(input string tag);
        int c;
        c = 0;
        while (busy === 1'b1 && c < 300) begin @(negedge px_clk); c++; end
        chk(tag, {31'd0, busy}, 32'd0);
        repeat (2) @(negedge px_clk);
    endtask

    task automatic check_frame(input string p, input int fv, input int lv0, input int stall,
                               input int fc);
        analyze();
        chk({p, ".fval_cyc"},  a_fv, fv);
        chk({p, ".fval_rise"}, a_fvrise, 1);
        chk({p, ".lead"},      a_lead, 1);
        chk({p, ".tail"},      a_tail, 1);
        chk({p, ".lval_n"},    a_nlv, 2);
        chk({p, ".lval0"},     a_lv[0], lv0);
        chk({p, ".lval1"},     a_lv[1], 4);
        chk({p, ".hgap"},      a_gap, 2);
        chk({p, ".stall"},     a_stall, stall);
        chk({p, ".word_viol"}, a_viol, 0);
        chk({p, ".npix"},      a_data.size(), 8);
        for (int i = 0; i < 8 && i < a_data.size(); i++) chk({p, ".pix"}, a_data[i], i + 1);
        chk({p, ".frame_cnt"}, frame_cnt, fc);
    endtask

    initial begin
        int cyc, tot;
        idle_bus();

        // reset state
        @(negedge px_clk);
        chk("rst.data",  DATA_OUT, 0);
        chk("rst.fval",  fval, 0);
        chk("rst.lval",  lval, 0);
        chk("rst.dval",  dval, 0);
        chk("rst.busy",  busy, 0);
        chk("rst.fcnt",  frame_cnt, 0);
        chk("rst.ready", sif.s_tready, 0);
        chk("rst.errs",  {err_line, err_sof}, 0);
        @(posedge px_clk); #2;
        rst = 1'b0;
        enable = 1'b1;

        // basic 4x2 frame
        lg_start = lg.size();
        send_frame(-1, -1, -1, 0, -1);
        wait_idle("t1.idle");
        check_frame("t1", 12, 4, 0, 1);
        chk("t1.err_line", a_el, 0);
        chk("t1.err_sof",  a_es, 0);

        // 3-cycle stall after pixel 2
        lg_start = lg.size();
        send_frame(-1, -1, 1, 3, -1);
        wait_idle("t2.idle");
        check_frame("t2", 15, 7, 3, 2);

        // early tlast on pixel 3 (tlast also on 4)
        lg_start = lg.size();
        send_frame(2, -1, -1, 0, -1);
        wait_idle("t3.idle");
        check_frame("t3", 12, 4, 0, 3);
        chk("t3.err_line_n",  a_el, 1);
        chk("t3.err_line_px", a_el_dat, 3);
        chk("t3.err_sof",     a_es, 0);

        // resync: 5 non-SOF beats dropped in IDLE, then SOF frame with stray tuser on pixel 6
        lg_start = lg.size();
        tot = 0;
        for (int j = 0; j < 5; j++) begin
            send_beat(24'hAA0000 + 24'(j), 1'b0, 1'b0, cyc);
            tot += cyc;
        end
        chk("t4.drop_cycles", tot, 5);
        send_frame(-1, 5, -1, 0, -1);
        wait_idle("t4.idle");
        check_frame("t4", 12, 4, 0, 4);
        chk("t4.err_sof_n",  a_es, 1);
        chk("t4.err_sof_px", a_es_dat, 6);
        chk("t4.err_line",   a_el, 0);

        // enable dropped mid-frame: frame completes, pending SOF then waits
        lg_start = lg.size();
        send_frame(-1, -1, -1, 0, 0);
        wait_idle("t5.idle");
        check_frame("t5", 12, 4, 0, 5);
        lg_start = lg.size();
        sif.s_tdata = 24'd1; sif.s_tuser = 1'b1; sif.s_tvalid = 1'b1;
        repeat (20) @(negedge px_clk);
        chk("t5.hold_ready", sif.s_tready, 0);
        chk("t5.hold_busy",  busy, 0);
        analyze();
        chk("t5.hold_fval",  a_fv, 0);
        chk("t5.hold_fcnt",  frame_cnt, 5);
        @(posedge px_clk); #1;

        // reset in the middle of line 0
        enable = 1'b1;
        send_beat(24'd1, 1'b1, 1'b0, cyc);
        send_beat(24'd2, 1'b0, 1'b0, cyc);
        sif.s_tdata = 24'd3; sif.s_tuser = 1'b0;
        chk("t6.pre_lval", lval, 1);
        chk("t6.pre_busy", busy, 1);
        #2 rst = 1'b1;
        #1;
        chk("t6.data",  DATA_OUT, 0);
        chk("t6.fval",  fval, 0);
        chk("t6.lval",  lval, 0);
        chk("t6.busy",  busy, 0);
        chk("t6.fcnt",  frame_cnt, 0);
        chk("t6.ready", sif.s_tready, 0);
        idle_bus();
        repeat (2) @(posedge px_clk);
        #2 rst = 1'b0;
        lg_start = lg.size();
        send_frame(-1, -1, -1, 0, -1);
        wait_idle("t6.idle");
        check_frame("t6", 12, 4, 0, 1);
        chk("t6.errs", a_el + a_es, 0);

        // zero width/height behave as 1x1
        cfg_width = 16'd0; cfg_height = 16'd0;
        lg_start = lg.size();
        send_beat(24'h123456, 1'b1, 1'b1, cyc);
        idle_bus();
        wait_idle("t7.idle");
        analyze();
        chk("t7.fval_cyc", a_fv, 3);
        chk("t7.lval_n",   a_nlv, 1);
        chk("t7.lval0",    a_lv[0], 1);
        chk("t7.npix",     a_data.size(), 1);
        if (a_data.size() > 0) chk("t7.pix", a_data[0], 32'h123456);
        chk("t7.errs",     a_el + a_es, 0);
        chk("t7.fcnt",     frame_cnt, 2);

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
